// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, FSM encoding and trap word shared by the Alu arbiter.
package alu_ctrl_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  localparam logic [31:0] TRAP_WORD = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker; searches from ptr+1 upward, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_gnt,
  output logic            o_gnt_valid
);
  always_comb begin
    o_gnt = '0;
    o_gnt_valid = 1'b0;
    // Scan distances from farthest to nearest so the nearest valid requester wins.
    for (int k = NREQ - 1; k >= 0; k--)
      for (int i = 0; i < NREQ; i++)
        if (i_req[i] && i == (int'(i_ptr) + 1 + k) % NREQ) begin
          o_gnt = IDW'(i);
          o_gnt_valid = 1'b1;
        end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: one registered 32-bit Alu shared round-robin among NREQ requesters.
// Optional ALU_ARB_ILLEGAL_OP_TRAP_EN flags ops 011/111 and returns 32'hDEAD_BEEF.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_op,
  input  logic [NREQ-1:0]  req_unsig,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_comp,
  output logic             rsp_overflow,
  output logic             rsp_err
);
  state_t r_state, w_next;
  logic [IDW-1:0] r_ptr, r_id, w_gnt;
  logic w_gnt_valid, w_accept, r_unsig, w_sel_u, w_comp, w_ovf, w_err;
  logic [31:0] r_a, r_b, w_sel_a, w_sel_b, w_add, w_sub, w_alu, w_res;
  logic [2:0] r_op, w_sel_op;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .i_req(req_valid), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_gnt_valid(w_gnt_valid)
  );

  assign w_accept = w_gnt_valid && (r_state == IDLE || (r_state == RESP && rsp_ready));
  assign req_ready = w_accept ? NREQ'(1) << w_gnt : '0;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_sel_op = '0;
    w_sel_u = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (IDW'(i) == w_gnt) begin
        w_sel_a = req_a[32*i +: 32];
        w_sel_b = req_b[32*i +: 32];
        w_sel_op = req_op[3*i +: 3];
        w_sel_u = req_unsig[i];
      end
  end

  always_comb
    w_next = r_state == EXEC ? RESP :
             w_accept ? EXEC :
             (r_state == RESP && rsp_ready) ? IDLE : r_state;

  assign w_add = r_a + r_b;
  assign w_sub = r_a - r_b;
  always_comb
    w_alu = r_op == OP_AND ? r_a & r_b :
            r_op == OP_OR  ? r_a | r_b :
            r_op == OP_ADD ? w_add :
            r_op == OP_NOR ? ~(r_a | r_b) :
            r_op == OP_XOR ? r_a ^ r_b :
            r_op == OP_SUB ? w_sub : 32'd0;
  assign w_comp = r_unsig ? r_a < r_b : $signed(r_a) < $signed(r_b);
  // Overflow derived from operand/result signs, only where it is possible.
  assign w_ovf = (r_op == OP_ADD && r_a[31] == r_b[31] && w_add[31] != r_a[31]) ||
                 (r_op == OP_SUB && r_a[31] != r_b[31] && w_sub[31] != r_a[31]);
`ifdef ALU_ARB_ILLEGAL_OP_TRAP_EN
  assign w_err = r_op[1:0] == 2'b11;
  assign w_res = w_err ? TRAP_WORD : w_alu;
`else
  assign w_err = 1'b0;
  assign w_res = w_alu;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= IDW'(NREQ - 1);
      r_id <= '0;
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_unsig <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_comp <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ptr <= w_gnt;
        r_id <= w_gnt;
        r_a <= w_sel_a;
        r_b <= w_sel_b;
        r_op <= w_sel_op;
        r_unsig <= w_sel_u;
      end
      if (r_state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id <= r_id;
        rsp_result <= w_res;
        rsp_comp <= w_comp;
        rsp_overflow <= w_ovf;
        rsp_err <= w_err;
      end else if (r_state == RESP && rsp_ready)
        rsp_valid <= 1'b0;
    end
endmodule
